dropout_lane_scheduler: RTL
===========================

Name: dropout_lane_scheduler

Overview:
Controller that sequences the 8-lane random-dropout datapath for one inference step. It generates a per-lane keep mask from an on-block LFSR against a programmable drop threshold. It then streams the lane activations through a valid/ready pipe, zeroing dropped lanes. It sits between the input switch bus (ui_in) and the dropout output bus (uo_out) in the top-level wrapper.

Parameters:
NUM_LANES, 8, lanes per step (power of two, 2..8)
DATA_W, 8, activation width
LFSR_W, 16, LFSR width
SEED, 16'hACE1, LFSR reset/fallback seed (must be nonzero)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
cfg_we  input  1  write cfg_thresh (IDLE only)
cfg_thresh  input  8  drop threshold
seed_we  input  1  load LFSR seed (IDLE only)
seed_val  input  LFSR_W  seed value
start  input  1  begin one step
in_valid  input  1  lane activation valid
in_data  input  DATA_W  lane activation
in_ready  output  1  lane accepted when in_valid&in_ready
out_valid  output  1  output lane valid
out_data  output  DATA_W  masked activation
out_lane  output  3  lane index of out_data
out_ready  input  1  downstream ready
mask  output  NUM_LANES  keep mask of current step (1 = keep)
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse at step end

Behaviour:
- Reset (async, rst_n=0): state IDLE, thresh=0x00, lfsr=SEED, mask=0, in_ready=0, out_valid=0, out_data=0, out_lane=0, busy=0, done=0.
- Everything is registered. With ena=0 no register changes, in_ready is forced 0, and outputs hold.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shifts right one step per cycle in GEN only. seed_we with seed_val=0 loads SEED instead.
- Keep rule: lane kept iff lfsr[7:0] >= thresh, compared unsigned, using the LFSR value before that cycle's step. thresh=0 keeps all lanes.
- States:
  - IDLE: cfg_we/seed_we take effect here; if both are asserted with start, the config writes first and start is honoured the next cycle. start&ena -> GEN, mask cleared, counter=0.
  - GEN: NUM_LANES cycles. Cycle i writes mask[i] and steps the LFSR. After lane N-1 -> STREAM with counter=0.
  - STREAM: in_ready = out_ready | ~out_valid. Lane accept captures out_data = mask[counter] ? in_data : 0 and out_lane=counter, sets out_valid the next cycle, and increments counter. Latency is 1 cycle. Full throughput is 1 lane/cycle. out_valid drops when out_ready is taken and no new lane is accepted. After lane N-1 is accepted and its output taken -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start, cfg_we and seed_we are ignored while busy.
- out_data, out_lane and out_valid hold stable while out_valid&~out_ready (no drop, no overwrite).
- mask stays valid from GEN exit until the next start.
- Counter is clog2(NUM_LANES) wide; out_lane is zero-extended to 3 bits.
- Reset mid-step aborts immediately. No partial output is retained.

Optional Feature:
DROPOUT_STATS_EN: adds output drop_count[15:0], reset 0. It increments by popcount(~mask) at GEN exit and saturates at 16'hFFFF. Without the macro the port is absent and there is no counter logic.

Test Plan:
- Reset, thresh=0x00, start, stream lanes 0x11..0x88 with out_ready=1 -> mask=0xFF; out_data 0x11..0x88 on lanes 0..7, one per cycle, 1-cycle latency; done pulses once; busy falls the same cycle.
- seed_we with seed_val=0, thresh=0x80, start -> LFSR reloads SEED; mask and zeroed lanes match the golden Galois model starting at 16'hACE1; dropped lanes output 0x00.
- thresh=0xFF, seed 0xACE1 -> only lanes whose lfsr[7:0]==0xFF are kept (model check); with DROPOUT_STATS_EN, drop_count equals 8-popcount(mask).
- out_ready toggled 1/0 every cycle during STREAM -> no lane lost or duplicated; out_data stable while stalled; 8 outputs total.
- cfg_we=1 with thresh=0xFF while busy -> ignored; the next step uses the old thresh. start while busy -> no restart.
- rst_n pulsed low at STREAM lane 4 -> outputs go to reset values at once; a new start runs a full 8-lane step from lfsr=SEED.

Source files
------------

// File: rtl/dropout_lane_scheduler.sv
// ============================================================================
// Module      : dropout_lane_scheduler
// Description : Sequences one inference step of the lane dropout datapath.
//               A Galois LFSR drawn against a programmable threshold builds
//               a per-lane keep mask. Lane activations then stream through a
//               one-deep valid/ready stage, and dropped lanes are zeroed.
//               Optional feature macro: DROPOUT_STATS_EN (adds drop_count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dropout_lane_scheduler #(
    parameter int                NUM_LANES = 8,
    parameter int                DATA_W    = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_thresh,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_lane,
    input  logic              out_ready,
    output logic [NUM_LANES-1:0] mask,
`ifdef DROPOUT_STATS_EN
    output logic [15:0]       drop_count,
`endif
    output logic              busy,
    output logic              done
);

    localparam int                c_cnt_w = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_LANES - 1);
    localparam logic [LFSR_W-1:0] c_poly  = LFSR_W'(16'hB400);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_gen    = 2'd1;
    localparam logic [1:0] c_stream = 2'd2;
    localparam logic [1:0] c_done   = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [7:0]           r_thresh;
    logic [LFSR_W-1:0]    r_lfsr;
    logic [LFSR_W-1:0]    w_lfsr_nxt;
    logic [NUM_LANES-1:0] r_mask;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_all_in;     // last lane of the step has been accepted
    logic                 r_start_pend; // start deferred behind a same-cycle config write
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [2:0]           r_out_lane;
    logic                 w_go;
    logic                 w_keep;
    logic                 w_accept;
    logic [2:0]           w_lane;

    // Start is taken directly unless a config write shares the cycle; then it is replayed next cycle
    assign w_go       = (start && !cfg_we && !seed_we) || r_start_pend;
    assign w_lfsr_nxt = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? c_poly : '0);
    assign w_keep     = (r_lfsr[7:0] >= r_thresh);
    assign w_accept   = in_valid && in_ready;

    // Zero-extend the lane counter onto the fixed 3-bit lane bus
    always_comb begin
        w_lane                = '0;
        w_lane[c_cnt_w-1:0]   = r_cnt;
    end

    // State register; ena low freezes the sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:   if (w_go) w_state_nxt = c_gen;
            c_gen:    if (r_cnt == c_last) w_state_nxt = c_stream;
            c_stream: if (r_all_in && r_out_valid && out_ready) w_state_nxt = c_done;
            c_done:   w_state_nxt = c_idle;
            default:  w_state_nxt = c_idle;
        endcase
    end

    // State-decoded outputs; the lane input only opens in STREAM while the output slot can drain
    always_comb begin
        in_ready = ena && (r_state == c_stream) && !r_all_in && (out_ready || !r_out_valid);
        busy     = (r_state != c_idle);
        done     = (r_state == c_done);
    end

    // Datapath: config, LFSR, mask generation and the output holding stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh     <= 8'h00;
            r_lfsr       <= SEED;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_all_in     <= 1'b0;
            r_start_pend <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_lane   <= '0;
        end else if (ena) begin
            case (r_state)
                c_idle: begin
                    if (cfg_we) r_thresh <= cfg_thresh;
                    if (seed_we) r_lfsr <= (seed_val == '0) ? SEED : seed_val;
                    r_start_pend <= !w_go && start && (cfg_we || seed_we);
                    if (w_go) begin
                        r_mask   <= '0;
                        r_cnt    <= '0;
                        r_all_in <= 1'b0;
                    end
                end
                c_gen: begin
                    r_mask[r_cnt] <= w_keep;
                    r_lfsr        <= w_lfsr_nxt;
                    r_cnt         <= r_cnt + 1'b1;
                end
                c_stream: begin
                    if (w_accept) begin
                        r_out_data  <= r_mask[r_cnt] ? in_data : '0;
                        r_out_lane  <= w_lane;
                        r_out_valid <= 1'b1;
                        r_cnt       <= r_cnt + 1'b1;
                        if (r_cnt == c_last) r_all_in <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DROPOUT_STATS_EN
    logic [NUM_LANES-1:0] w_mask_final;
    logic [15:0]          w_drops;
    logic [16:0]          w_drop_sum;
    logic [15:0]          r_drop_count;

    // Count dropped lanes of the mask as it will stand after the last GEN write
    always_comb begin
        w_mask_final        = r_mask;
        w_mask_final[r_cnt] = w_keep;
        w_drops             = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_drops = w_drops + {15'd0, ~w_mask_final[i]};
        end
        w_drop_sum = {1'b0, r_drop_count} + {1'b0, w_drops};
    end

    // Saturating accumulation of dropped lanes at each GEN exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (ena && (r_state == c_gen) && (r_cnt == c_last)) begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign mask      = r_mask;

endmodule

`default_nettype wire
